reg_scoreboard: RTL and testbench

//  Architectural register file plus per-register pending-write scoreboard, directly upstream of Read.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/sb_counter.sv | 26 ++
 rtl/reg_scoreboard.sv | 77 +++++++
 tb/tb_reg_scoreboard.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: architectural register codes and shared datapath types.
package cpu_pkg;
    typedef logic [3:0]  regcode_t;
    typedef logic [63:0] regval_t;
    localparam regcode_t REG_RAX = 4'd0;
    localparam regcode_t REG_RCX = 4'd1;
    localparam regcode_t REG_RDX = 4'd2;
    localparam regcode_t REG_RBX = 4'd3;
    localparam regcode_t REG_RSP = 4'd4;
    localparam regcode_t REG_RBP = 4'd5;
    localparam regcode_t REG_RSI = 4'd6;
    localparam regcode_t REG_RDI = 4'd7;
    localparam regcode_t REG_R8  = 4'd8;
    localparam regcode_t REG_R9  = 4'd9;
    localparam regcode_t REG_R10 = 4'd10;
    localparam regcode_t REG_R11 = 4'd11;
    localparam regcode_t REG_R12 = 4'd12;
    localparam regcode_t REG_R13 = 4'd13;
    localparam regcode_t REG_R14 = 4'd14;
    localparam regcode_t REG_R15 = 4'd15;
endpackage

// File: rtl/sb_counter.sv
// sb_counter: saturating pending-writer counter; flags underflow/overflow for one cycle.
module sb_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         inc_i,
    input  logic [1:0]   dec_i,
    output logic [W-1:0] count_o,
    output logic         err_o
);
    localparam int MAX = 2 ** W - 1;
    logic [W-1:0]      count_q, count_d;
    logic signed [W+1:0] net;
    always_comb begin
        net = $signed({2'b00, count_q}) + $signed({{(W + 1){1'b0}}, inc_i}) - $signed({{W{1'b0}}, dec_i});
        count_d = clear_i ? '0 : (net < 0) ? '0 : (net > MAX) ? W'(MAX) : net[W-1:0];
        err_o = !clear_i && ((net < 0) || (net > MAX));
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else count_q <= count_d;
    end
    assign count_o = count_q;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: register file image with same-cycle writeback forwarding and a
// per-register pending-writer scoreboard that qualifies entry into Read.
module reg_scoreboard
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 64,
    parameter int PEND_W   = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [1:0]                         srcValidIn,
    input  regcode_t                           src1In,
    input  regcode_t                           src2In,
    input  logic [1:0]                         destValidIn,
    input  regcode_t                           destIn,
    input  regcode_t                           destSpecialIn,
    input  logic                               issueIn,
    input  logic                               stallIn,
    input  logic                               flushIn,
    input  logic [1:0]                         wbValidIn,
    input  regcode_t                           wbRegAIn,
    input  logic [REG_W-1:0]                   wbDataAIn,
    input  regcode_t                           wbRegBIn,
    input  logic [REG_W-1:0]                   wbDataBIn,
    output logic [NUM_REGS-1:0][REG_W-1:0]     registerFileOut,
    output logic                               canReadOut,
    output logic                               issueFireOut,
    output logic [NUM_REGS-1:0]                pendingOut,
    output logic                               errorOut
);
    logic [NUM_REGS-1:0][REG_W-1:0] regs_q;
    logic [PEND_W-1:0]              cnt [NUM_REGS];
    logic [1:0]                     dec [NUM_REGS];
    logic [NUM_REGS-1:0]            busy, inc, cnt_err;
    logic                           error_q;

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        logic hit_a, hit_b;
        assign hit_a = wbValidIn[0] && (wbRegAIn == regcode_t'(r));
        assign hit_b = wbValidIn[1] && (wbRegBIn == regcode_t'(r));
        // Port B wins a same-register collision, both in the image and in storage.
        assign registerFileOut[r] = hit_b ? wbDataBIn : hit_a ? wbDataAIn : regs_q[r];
        assign dec[r] = {1'b0, hit_a} + {1'b0, hit_b};
        assign inc[r] = issueFireOut && ((destValidIn[0] && (destIn == regcode_t'(r))) ||
                                         (destValidIn[1] && (destSpecialIn == regcode_t'(r))));
        assign busy[r] = int'(cnt[r]) > int'(dec[r]);
        assign pendingOut[r] = cnt[r] != '0;
        sb_counter #(.W(PEND_W)) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clear_i (flushIn),
            .inc_i   (inc[r]),
            .dec_i   (dec[r]),
            .count_o (cnt[r]),
            .err_o   (cnt_err[r])
        );
    end

    // Destination limit looks at the raw count: a retiring writer does not free a slot this cycle.
    assign canReadOut = issueIn && !flushIn
        && !(srcValidIn[0] && busy[src1In]) && !(srcValidIn[1] && busy[src2In])
        && !(destValidIn[0] && (cnt[destIn] == '1))
        && !(destValidIn[1] && (cnt[destSpecialIn] == '1));
    assign issueFireOut = canReadOut && !stallIn && !reset;
    assign errorOut = error_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q  <= '0;
            error_q <= 1'b0;
        end else begin
            regs_q  <= registerFileOut;
            error_q <= error_q | (|cnt_err);
        end
    end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenario tasks with hand-computed expectations.
module tb_reg_scoreboard;
    import cpu_pkg::*;
    logic clk = 1'b0, reset;
    logic [1:0] srcValidIn, destValidIn, wbValidIn;
    regcode_t src1In, src2In, destIn, destSpecialIn, wbRegAIn, wbRegBIn;
    logic issueIn, stallIn, flushIn;
    regval_t wbDataAIn, wbDataBIn;
    logic [15:0][63:0] registerFileOut;
    logic canReadOut, issueFireOut, errorOut;
    logic [15:0] pendingOut;
    int checks = 0, fails = 0;

    reg_scoreboard dut (
        .clk(clk), .reset(reset), .srcValidIn(srcValidIn), .src1In(src1In), .src2In(src2In),
        .destValidIn(destValidIn), .destIn(destIn), .destSpecialIn(destSpecialIn),
        .issueIn(issueIn), .stallIn(stallIn), .flushIn(flushIn), .wbValidIn(wbValidIn),
        .wbRegAIn(wbRegAIn), .wbDataAIn(wbDataAIn), .wbRegBIn(wbRegBIn), .wbDataBIn(wbDataBIn),
        .registerFileOut(registerFileOut), .canReadOut(canReadOut), .issueFireOut(issueFireOut),
        .pendingOut(pendingOut), .errorOut(errorOut)
    );

    always #5 clk = ~clk;

    task automatic idle();
        srcValidIn = 0; src1In = 0; src2In = 0; destValidIn = 0; destIn = 0; destSpecialIn = 0;
        issueIn = 0; stallIn = 0; flushIn = 0; wbValidIn = 0; wbRegAIn = 0; wbRegBIn = 0;
        wbDataAIn = 0; wbDataBIn = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_dest(input regcode_t d);
        idle(); issueIn = 1; destValidIn = 2'b01; destIn = d;
    endtask

    task automatic test_reset();
        issue_dest(REG_RBX); #1;
        checks++; if (issueFireOut !== 1'b1) begin fails++; $display("FAIL rst_issue: got %b want 1", issueFireOut); end
        tick(); tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0008) begin fails++; $display("FAIL rst_pend_pre: got %h want 0008", pendingOut); end
        wbValidIn = 2'b01; wbRegAIn = REG_RBP; wbDataAIn = 64'hdead; tick(); idle(); #1;
        checks++; if (errorOut !== 1'b1) begin fails++; $display("FAIL rst_err_pre: got %b want 1", errorOut); end
        reset = 1; issueIn = 1; #1;
        checks++; if (pendingOut !== 16'h0) begin fails++; $display("FAIL rst_pend: got %h want 0000", pendingOut); end
        checks++; if (registerFileOut !== '0) begin fails++; $display("FAIL rst_rf: got rf5=%h want all 0", registerFileOut[5]); end
        checks++; if (errorOut !== 1'b0) begin fails++; $display("FAIL rst_err: got %b want 0", errorOut); end
        checks++; if (issueFireOut !== 1'b0) begin fails++; $display("FAIL rst_fire: got %b want 0", issueFireOut); end
        checks++; if (canReadOut !== 1'b1) begin fails++; $display("FAIL rst_canread: got %b want 1", canReadOut); end
        tick(); reset = 0; idle(); tick();
        checks++; if (pendingOut !== 16'h0) begin fails++; $display("FAIL rst_pend_post: got %h want 0000", pendingOut); end
    endtask

    task automatic test_raw_forward();
        issue_dest(REG_RAX); tick();
        idle(); issueIn = 1; srcValidIn = 2'b01; src1In = REG_RAX; #1;
        checks++; if (canReadOut !== 1'b0) begin fails++; $display("FAIL raw_block: got %b want 0", canReadOut); end
        wbValidIn = 2'b01; wbRegAIn = REG_RAX; wbDataAIn = 64'h1234; #1;
        checks++; if (canReadOut !== 1'b1) begin fails++; $display("FAIL raw_fwd_canread: got %b want 1", canReadOut); end
        checks++; if (registerFileOut[0] !== 64'h1234) begin fails++; $display("FAIL raw_fwd_data: got %h want 1234", registerFileOut[0]); end
        tick(); idle(); #1;
        checks++; if (registerFileOut[0] !== 64'h1234) begin fails++; $display("FAIL raw_stored: got %h want 1234", registerFileOut[0]); end
        checks++; if (pendingOut !== 16'h0) begin fails++; $display("FAIL raw_pend: got %h want 0000", pendingOut); end
    endtask

    task automatic test_waw_limit();
        issue_dest(REG_RBX);
        for (int i = 0; i < 3; i++) begin
            #1; checks++; if (issueFireOut !== 1'b1) begin fails++; $display("FAIL waw_fire%0d: got %b want 1", i, issueFireOut); end
            tick();
        end
        checks++; if (canReadOut !== 1'b0) begin fails++; $display("FAIL waw_full: got %b want 0", canReadOut); end
        wbValidIn = 2'b01; wbRegAIn = REG_RBX; wbDataAIn = 64'h7; #1;
        checks++; if (canReadOut !== 1'b0) begin fails++; $display("FAIL waw_full_wb: got %b want 0", canReadOut); end
        tick(); wbValidIn = 0; #1;
        checks++; if (issueFireOut !== 1'b1) begin fails++; $display("FAIL waw_resume: got %b want 1", issueFireOut); end
        tick(); idle(); wbValidIn = 2'b01; wbRegAIn = REG_RBX; wbDataAIn = 64'h8;
        repeat (3) tick();
        idle(); #1;
        checks++; if (pendingOut !== 16'h0) begin fails++; $display("FAIL waw_drain: got %h want 0000", pendingOut); end
        checks++; if (errorOut !== 1'b0) begin fails++; $display("FAIL waw_err: got %b want 0", errorOut); end
    endtask

    task automatic test_inc_dec_same();
        issue_dest(REG_RCX); tick();
        wbValidIn = 2'b01; wbRegAIn = REG_RCX; wbDataAIn = 64'h99; #1;
        checks++; if (issueFireOut !== 1'b1) begin fails++; $display("FAIL incdec_fire: got %b want 1", issueFireOut); end
        tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0002) begin fails++; $display("FAIL incdec_pend: got %h want 0002", pendingOut); end
        checks++; if (registerFileOut[1] !== 64'h99) begin fails++; $display("FAIL incdec_data: got %h want 99", registerFileOut[1]); end
        wbValidIn = 2'b01; wbRegAIn = REG_RCX; wbDataAIn = 64'h9a; tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0 || errorOut !== 1'b0) begin fails++; $display("FAIL incdec_drain: got pend=%h err=%b want 0000/0", pendingOut, errorOut); end
    endtask

    task automatic test_stall_special();
        issue_dest(REG_RSI); stallIn = 1; #1;
        checks++; if (canReadOut !== 1'b1 || issueFireOut !== 1'b0) begin fails++; $display("FAIL stall: got can=%b fire=%b want 1/0", canReadOut, issueFireOut); end
        tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0) begin fails++; $display("FAIL stall_pend: got %h want 0000", pendingOut); end
        issue_dest(REG_RDI); destValidIn = 2'b11; destSpecialIn = REG_RDI; tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0080) begin fails++; $display("FAIL spec_same: got %h want 0080", pendingOut); end
        wbValidIn = 2'b01; wbRegAIn = REG_RDI; tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0 || errorOut !== 1'b0) begin fails++; $display("FAIL spec_same_wb: got pend=%h err=%b want 0000/0", pendingOut, errorOut); end
        issue_dest(REG_RAX); destValidIn = 2'b11; destSpecialIn = REG_RDX; tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0005) begin fails++; $display("FAIL spec_pair: got %h want 0005", pendingOut); end
        wbValidIn = 2'b11; wbRegAIn = REG_RAX; wbRegBIn = REG_RDX; tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0 || errorOut !== 1'b0) begin fails++; $display("FAIL spec_pair_wb: got pend=%h err=%b want 0000/0", pendingOut, errorOut); end
    endtask

    task automatic test_flush();
        issue_dest(REG_RCX); tick();
        destIn = REG_RDX; repeat (3) tick();
        idle(); #1;
        checks++; if (pendingOut !== 16'h0006) begin fails++; $display("FAIL flush_pre: got %h want 0006", pendingOut); end
        issue_dest(REG_RSP); flushIn = 1; wbValidIn = 2'b11;
        wbRegAIn = REG_RCX; wbDataAIn = 64'h55; wbRegBIn = REG_RBP; wbDataBIn = 64'h66; #1;
        checks++; if (canReadOut !== 1'b0 || issueFireOut !== 1'b0) begin fails++; $display("FAIL flush_gate: got can=%b fire=%b want 0/0", canReadOut, issueFireOut); end
        tick(); idle(); #1;
        checks++; if (pendingOut !== 16'h0) begin fails++; $display("FAIL flush_pend: got %h want 0000", pendingOut); end
        checks++; if (errorOut !== 1'b0) begin fails++; $display("FAIL flush_err: got %b want 0", errorOut); end
        checks++; if (registerFileOut[1] !== 64'h55 || registerFileOut[5] !== 64'h66) begin fails++; $display("FAIL flush_data: got %h/%h want 55/66", registerFileOut[1], registerFileOut[5]); end
    endtask

    task automatic test_back_to_back();
        issue_dest(REG_R8); tick(); tick(); idle();
        wbValidIn = 2'b11; wbRegAIn = REG_R8; wbDataAIn = 64'h11; wbRegBIn = REG_R8; wbDataBIn = 64'h22; #1;
        checks++; if (registerFileOut[8] !== 64'h22) begin fails++; $display("FAIL b2b_fwd: got %h want 22", registerFileOut[8]); end
        tick(); idle(); #1;
        checks++; if (registerFileOut[8] !== 64'h22) begin fails++; $display("FAIL b2b_stored: got %h want 22", registerFileOut[8]); end
        checks++; if (pendingOut !== 16'h0 || errorOut !== 1'b0) begin fails++; $display("FAIL b2b_pend: got pend=%h err=%b want 0000/0", pendingOut, errorOut); end
        wbValidIn = 2'b01; wbRegAIn = REG_R9; wbDataAIn = 64'h33; tick(); idle(); #1;
        checks++; if (errorOut !== 1'b1) begin fails++; $display("FAIL underflow_err: got %b want 1", errorOut); end
        checks++; if (registerFileOut[9] !== 64'h33 || pendingOut !== 16'h0) begin fails++; $display("FAIL underflow_state: got r9=%h pend=%h want 33/0000", registerFileOut[9], pendingOut); end
        repeat (3) tick();
        checks++; if (errorOut !== 1'b1) begin fails++; $display("FAIL err_sticky: got %b want 1", errorOut); end
    endtask

    initial begin
        idle(); reset = 1;
        repeat (2) @(posedge clk);
        #1; reset = 0; tick();
        test_reset();
        test_raw_forward();
        test_waw_limit();
        test_inc_dec_same();
        test_stall_special();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
